pattern_sweep_capture: RTL and testbench

Synthesizable on-chip replacement for per-benchmark exhaustive-sweep benches. It drives an N_IN-bit pattern stream into a combinational or sequential DUT and waits a programmable settle time. It then samples the DUT response and hands each {pattern, response} record downstream over a valid/ready stream, compressing all responses into a MISR signature for golden-vs-trojan comparison. It sits between the sweep controller and the record writer in the trojan-detection data-generation flow.

---
 rtl/sweep_pkg.sv | 54 +++++
 rtl/sweep_misr.sv | 35 +++
 rtl/pattern_sweep_capture.sv | 156 +++++++++++++++
 tb/tb_pattern_sweep_capture.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sweep_pkg
// Description : Shared types and helpers for the pattern sweep / capture
//               block: FSM state encoding, maximal-length LFSR tap table,
//               MISR polynomial and the LFSR step function.
// Revision    : 1.0 - initial release
// ============================================================================
package sweep_pkg;

  // Sweep controller states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_t;

  // MISR feedback polynomial (CRC-CCITT style)
  localparam logic [15:0] c_MISR_POLY = 16'h1021;

  // Maximal-length Fibonacci tap mask for widths 2..16; bit (t-1) set for tap t
  function automatic logic [15:0] lfsr_taps(input int width);
    case (width)
      2:       lfsr_taps = 16'h0003; // {2,1}
      3:       lfsr_taps = 16'h0006; // {3,2}
      4:       lfsr_taps = 16'h000C; // {4,3}
      5:       lfsr_taps = 16'h0014; // {5,3}
      6:       lfsr_taps = 16'h0030; // {6,5}
      7:       lfsr_taps = 16'h0060; // {7,6}
      8:       lfsr_taps = 16'h00B8; // {8,6,5,4}
      9:       lfsr_taps = 16'h0110; // {9,5}
      10:      lfsr_taps = 16'h0240; // {10,7}
      11:      lfsr_taps = 16'h0500; // {11,9}
      12:      lfsr_taps = 16'h0829; // {12,6,4,1}
      13:      lfsr_taps = 16'h100D; // {13,4,3,1}
      14:      lfsr_taps = 16'h2015; // {14,5,3,1}
      15:      lfsr_taps = 16'h6000; // {15,14}
      16:      lfsr_taps = 16'hD008; // {16,15,13,4}
      default: lfsr_taps = 16'h0000;
    endcase
  endfunction

  // One shift-left Fibonacci step; the result is confined to the low `width` bits
  function automatic logic [15:0] next_lfsr(input int width, input logic [15:0] value);
    logic [16:0] mask;
    logic        fb;
    mask      = (17'd1 << width) - 17'd1;
    fb        = ^(value & lfsr_taps(width));
    next_lfsr = {value[14:0], fb} & mask[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sweep_misr.sv
`default_nettype none
// ============================================================================
// Module      : sweep_misr
// Description : 16-bit multiple-input signature register with synchronous
//               clear and update enable. Shared with the record-writer checker.
// Revision    : 1.0 - initial release
// ============================================================================
module sweep_misr
  import sweep_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] data_in,
  output logic [15:0] signature
);

  logic [15:0] r_sig;

  // Signature register: shift with polynomial feedback, fold in the new data word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig <= 16'h0000;
    end else if (clear) begin
      r_sig <= 16'h0000;
    end else if (enable) begin
      r_sig <= {r_sig[14:0], 1'b0} ^ (r_sig[15] ? c_MISR_POLY : 16'h0000) ^ data_in;
    end
  end

  assign signature = r_sig;

endmodule
`default_nettype wire

// File: rtl/pattern_sweep_capture.sv
`default_nettype none
// ============================================================================
// Module      : pattern_sweep_capture
// Description : Drives an exhaustive pattern sweep (ascending or LFSR order)
//               into a DUT, waits a settle time, captures the response and
//               emits {pattern, response} records on a valid/ready stream
//               while compressing responses into a MISR signature.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_sweep_capture
  import sweep_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 1,
  parameter int SIG_W  = 16
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [N_IN-1:0]  seed,
  output logic [N_IN-1:0]  pat_o,
  input  logic [N_OUT-1:0] resp_i,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [N_IN-1:0]  rec_pattern,
  output logic [N_OUT-1:0] rec_response,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature
);

  localparam int                  c_CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [c_CNT_W-1:0]  c_SETTLE_LAST = c_CNT_W'(SETTLE - 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE     = c_CNT_W'(1);
  localparam logic [N_IN-1:0]     c_PAT_ONE     = N_IN'(1);
  localparam logic [N_IN-1:0]     c_PAT_ALL1    = '1;
  localparam logic [N_IN-1:0]     c_PAT_PENULT  = c_PAT_ALL1 - c_PAT_ONE;

  sweep_state_t        r_state;
  sweep_state_t        w_state_nxt;
  logic [N_IN-1:0]     r_pat;
  logic [N_OUT-1:0]    r_resp;
  logic [c_CNT_W-1:0]  r_settle;
  logic [N_IN-1:0]     r_count;    // index of the record currently in flight
  logic                r_mode;

  logic                w_start;
  logic                w_abort;
  logic                w_xfer;
  logic                w_commit;
  logic                w_settle_end;
  logic                w_last;
  logic [N_IN-1:0]     w_first;
  logic [N_IN-1:0]     w_lfsr_nxt;
  logic [N_IN-1:0]     w_pat_next;
  logic [15:0]         w_sig;

  assign w_start      = (r_state == ST_IDLE) && start;
  assign w_abort      = (r_state != ST_IDLE) && abort;
  assign w_xfer       = (r_state == ST_HOLD) && rec_ready;
  // abort wins over a coinciding transfer, so the record is not folded in
  assign w_commit     = w_xfer && !abort;
  assign w_settle_end = (r_state == ST_SETTLE) && (r_settle == c_SETTLE_LAST);
  assign w_last       = (r_count == c_PAT_ALL1);

  // LFSR mode never produces zero from a nonzero state, so zero is seeded in by hand
  assign w_first    = mode ? ((seed == '0) ? c_PAT_ONE : seed) : '0;
  assign w_lfsr_nxt = N_IN'(next_lfsr(N_IN, 16'(r_pat)));
  assign w_pat_next = r_mode ? ((r_count == c_PAT_PENULT) ? '0 : w_lfsr_nxt)
                             : (r_pat + c_PAT_ONE);

  // State register
  always_ff @(posedge CK) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start)        w_state_nxt = ST_SETTLE;
      ST_SETTLE: if (w_settle_end) w_state_nxt = ST_HOLD;
      ST_HOLD:   if (rec_ready)    w_state_nxt = w_last ? ST_DONE : ST_SETTLE;
      ST_DONE:                     w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // State-decoded outputs
  always_comb begin
    busy      = 1'b0;
    rec_valid = 1'b0;
    done      = 1'b0;
    case (r_state)
      ST_SETTLE: busy = 1'b1;
      ST_HOLD: begin
        busy      = 1'b1;
        rec_valid = 1'b1;
      end
      ST_DONE:   done = 1'b1;
      default: ;
    endcase
  end

  // Pattern, settle counter and response capture datapath
  always_ff @(posedge CK) begin
    if (reset) begin
      r_pat    <= '0;
      r_resp   <= '0;
      r_settle <= '0;
      r_count  <= '0;
      r_mode   <= 1'b0;
    end else if (w_start) begin
      r_pat    <= w_first;
      r_mode   <= mode;
      r_settle <= '0;
      r_count  <= '0;
    end else if ((r_state == ST_SETTLE) && !abort) begin
      if (w_settle_end) begin
        r_resp   <= resp_i;
        r_settle <= '0;
      end else begin
        r_settle <= r_settle + c_CNT_ONE;
      end
    end else if (w_commit && !w_last) begin
      r_pat   <= w_pat_next;
      r_count <= r_count + c_PAT_ONE;
    end
  end

  sweep_misr u_misr (
    .clk       (CK),
    .rst       (reset),
    .clear     (w_start),
    .enable    (w_commit),
    .data_in   (16'(r_resp)),
    .signature (w_sig)
  );

  assign pat_o        = r_pat;
  assign rec_pattern  = r_pat;
  assign rec_response = r_resp;
  assign signature    = SIG_W'(w_sig);

endmodule
`default_nettype wire

// File: tb/tb_pattern_sweep_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_sweep_capture
// Description : Directed self-checking bench for pattern_sweep_capture
//               (N_IN=3, N_OUT=1) with SETTLE=1 and SETTLE=3 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_sweep_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start1 = 1'b0, start3 = 1'b0, abort = 1'b0, mode = 1'b0;
  logic [2:0] seed = 3'd0;
  logic       ready1 = 1'b1, ready3 = 1'b1;
  logic [1:0] resp_sel = 2'd0;

  logic [2:0]  pat1, rp1, pat3, rp3;
  logic        resp1, resp3, valid1, valid3, rr1, rr3, busy1, busy3, done1, done3;
  logic [15:0] sig1, sig3;

  always #5 clk = ~clk;

  // Stimulus DUT behaviour: parity, stuck-at-0, or a single 1 on pattern 000
  assign resp1 = (resp_sel == 2'd0) ? ^pat1 : (resp_sel == 2'd1) ? 1'b0 : (pat1 == 3'd0);
  assign resp3 = ^pat3;

  pattern_sweep_capture #(.N_IN(3), .N_OUT(1), .SETTLE(1), .SIG_W(16)) dut (
    .CK(clk), .reset(reset), .start(start1), .abort(abort), .mode(mode), .seed(seed),
    .pat_o(pat1), .resp_i(resp1), .rec_valid(valid1), .rec_ready(ready1),
    .rec_pattern(rp1), .rec_response(rr1), .busy(busy1), .done(done1), .signature(sig1)
  );

  pattern_sweep_capture #(.N_IN(3), .N_OUT(1), .SETTLE(3), .SIG_W(16)) dut3 (
    .CK(clk), .reset(reset), .start(start3), .abort(abort), .mode(mode), .seed(seed),
    .pat_o(pat3), .resp_i(resp3), .rec_valid(valid3), .rec_ready(ready3),
    .rec_pattern(rp3), .rec_response(rr3), .busy(busy3), .done(done3), .signature(sig3)
  );

  int checks = 0;
  int errors = 0;

  logic [2:0] gp [8];
  logic       gr [8];
  int         gn, gcyc;
  logic       gdone, gboth;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full sweep on the SETTLE=1 instance with rec_ready held high
  task automatic sweep1(input logic m, input logic [2:0] sd);
    mode = m; seed = sd; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("busy_rise", busy1, 1);
    gn = 0; gcyc = 0; gdone = 1'b0; gboth = 1'b0;
    while (!gdone && gcyc < 200) begin
      if (valid1 && ready1) begin
        if (gn < 8) begin gp[gn] = rp1; gr[gn] = rr1; end
        gn++;
      end
      tick();
      gcyc++;
      if (busy1 && done1) gboth = 1'b1;
      if (done1) gdone = 1'b1;
    end
    check("done_seen", gdone, 1);
    check("done_busy_excl", gboth, 0);
  endtask

  task automatic cmp_records(input string tag, input logic [23:0] pats, input logic [7:0] resps);
    check($sformatf("%s_count", tag), gn, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_pat%0d", tag, i), gp[i], pats[i*3 +: 3]);
      check($sformatf("%s_resp%0d", tag, i), gr[i], resps[i]);
    end
  endtask

  task automatic after_done(input string tag);
    tick();
    check($sformatf("%s_done_pulse", tag), done1, 0);
  endtask

  logic [23:0] pats_asc, pats_lfsr1, pats_lfsr5;
  logic        no_done, prev_stall;
  logic [2:0]  prev_pat;
  logic        prev_resp;
  int          cyc;

  initial begin
    pats_asc   = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    pats_lfsr1 = {3'b000, 3'b100, 3'b110, 3'b111, 3'b011, 3'b101, 3'b010, 3'b001};
    pats_lfsr5 = {3'b000, 3'b010, 3'b001, 3'b100, 3'b110, 3'b111, 3'b011, 3'b101};

    // Reset state
    tick(); tick();
    check("rst_pat", pat1, 0);
    check("rst_valid", valid1, 0);
    check("rst_rec_pattern", rp1, 0);
    check("rst_rec_response", rr1, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_sig", sig1, 0);
    reset = 1'b0;
    tick();

    // Ascending sweep, parity responses
    sweep1(1'b0, 3'd0);
    check("m0_cycles", gcyc, 16);
    cmp_records("m0", pats_asc, 8'b10010110);
    check("m0_sig", sig1, 16'h0069);
    check("m0_done_busy", busy1, 0);
    after_done("m0");
    check("m0_sig_hold", sig1, 16'h0069);

    // LFSR sweep with zero seed: starts at 001, ends at 000
    sweep1(1'b1, 3'd0);
    cmp_records("m1", pats_lfsr1, 8'b01010011);
    check("m1_sig", sig1, 16'h00CA);
    after_done("m1");

    // Response tied low, then a single flipped response on record 0
    resp_sel = 2'd1;
    sweep1(1'b0, 3'd0);
    check("zero_sig", sig1, 16'h0000);
    after_done("zero");
    resp_sel = 2'd2;
    sweep1(1'b0, 3'd0);
    check("flip_sig", sig1, 16'h0080);
    after_done("flip");
    resp_sel = 2'd0;

    // Abort coinciding with the transfer of the fourth record
    mode = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    cyc = 0;
    while (!(valid1 && rp1 == 3'd3) && cyc < 50) begin tick(); cyc++; end
    check("abort_reach_rec4", valid1 && rp1 == 3'd3, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy1, 0);
    check("abort_valid", valid1, 0);
    check("abort_sig", sig1, 16'h0003);
    no_done = 1'b1;
    if (done1) no_done = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); if (done1) no_done = 1'b0; end
    check("abort_no_done", no_done, 1);
    check("abort_sig_hold", sig1, 16'h0003);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("restart_pat", pat1, 0);
    check("restart_sig", sig1, 0);
    check("restart_busy", busy1, 1);

    // Reset while a record is held, then an LFSR sweep from seed 101
    cyc = 0;
    while (!(valid1 && rp1 == 3'd2) && cyc < 50) begin tick(); cyc++; end
    check("rst_reach_hold", valid1, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_pat", pat1, 0);
    check("mrst_valid", valid1, 0);
    check("mrst_rec_response", rr1, 0);
    check("mrst_busy", busy1, 0);
    check("mrst_sig", sig1, 0);
    sweep1(1'b1, 3'd5);
    cmp_records("m1s5", pats_lfsr5, 8'b01110100);
    check("m1s5_sig", sig1, 16'h002E);
    after_done("m1s5");

    // SETTLE=3 instance with random back-pressure
    mode = 1'b0; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    gn = 0; cyc = 0; gdone = 1'b0; prev_stall = 1'b0; prev_pat = '0; prev_resp = 1'b0;
    while (!gdone && cyc < 500) begin
      if (prev_stall) begin
        check("stall_valid", valid3, 1);
        check("stall_rec_pattern", rp3, prev_pat);
        check("stall_rec_response", rr3, prev_resp);
        check("stall_pat_o", pat3, prev_pat);
      end
      ready3 = 1'($urandom_range(0, 1));
      if (valid3 && ready3) begin
        if (gn < 8) begin gp[gn] = rp3; gr[gn] = rr3; end
        gn++;
      end
      prev_stall = valid3 && !ready3;
      prev_pat   = rp3;
      prev_resp  = rr3;
      tick();
      cyc++;
      if (done3) gdone = 1'b1;
    end
    ready3 = 1'b1;
    check("s3_done_seen", gdone, 1);
    cmp_records("s3", pats_asc, 8'b10010110);
    check("s3_sig", sig3, 16'h0069);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
